// File: rtl/ysyx_uop_queue.sv
// ysyx_uop_queue: circular micro-op buffer between decode (IDU) and issue/EXU.
// A power-of-two ring with head/tail pointers and an occupancy counter.
// An optional empty-queue bypass lets a micro-op reach the consumer in the
// same cycle it is offered, without ever occupying a slot.
module ysyx_uop_queue #(
    parameter int UOP_W = 192,
    parameter int DEPTH = 4,
    parameter int PASS  = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [UOP_W-1:0]           in_uop,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [UOP_W-1:0]           out_uop,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam bit BYPASS = (PASS != 0);

    // Payload storage is deliberately left out of reset; only the pointers
    // and the counter decide which slots hold live micro-ops.
    logic [UOP_W-1:0] mem [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] occupancy;

    logic full;
    logic empty;
    logic bypass;
    logic enq;
    logic deq;

    assign full  = (occupancy == CW'(DEPTH));
    assign empty = (occupancy == '0);
    assign count = occupancy;

    // Handshake outputs and head selection; flush hides the queue from both sides.
    always_comb begin
        in_ready  = !full && !flush;
        out_valid = !empty && !flush;
        out_uop   = mem[head];
        if (BYPASS) begin
            out_valid = (!empty || in_valid) && !flush;
            if (empty) begin
                out_uop = in_uop;
            end
        end
    end

    // Classify this cycle's transfer; a bypass consumes the offered micro-op
    // directly, so it counts as neither an enqueue nor a dequeue of storage.
    always_comb begin
        bypass = BYPASS && empty && in_valid && out_ready && !flush;
        enq    = in_valid && in_ready && !bypass;
        deq    = out_valid && out_ready && !empty;
    end

    // Pointer and occupancy update; reset outranks flush, which outranks traffic.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            if (enq) begin
                tail <= tail + AW'(1);
            end
            if (deq) begin
                head <= head + AW'(1);
            end
            case ({enq, deq})
                2'b10:   occupancy <= occupancy + CW'(1);
                2'b01:   occupancy <= occupancy - CW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Payload write into the tail slot; only freed slots are ever overwritten.
    always_ff @(posedge clock) begin
        if (!reset && enq) begin
            mem[tail] <= in_uop;
        end
    end

endmodule

// File: tb/tb_ysyx_uop_queue.sv
// Testbench for ysyx_uop_queue: a PASS=0 and a PASS=1 instance share the same
// stimulus; each is compared every cycle against a queue-based model, and a
// set of directed scenarios pins literal expectations.
module tb_ysyx_uop_queue;

    localparam int UOP_W = 192;
    localparam int DEPTH = 4;

    logic             clock;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic [UOP_W-1:0] in_uop;
    logic             out_ready;

    logic             in_ready0,  in_ready1;
    logic             out_valid0, out_valid1;
    logic [UOP_W-1:0] out_uop0,   out_uop1;
    logic [2:0]       count0,     count1;

    int nChecks = 0;
    int nFails  = 0;

    ysyx_uop_queue #(.UOP_W(UOP_W), .DEPTH(DEPTH), .PASS(0)) u0 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_uop(in_uop),
        .out_valid(out_valid0), .out_ready(out_ready), .out_uop(out_uop0),
        .count(count0)
    );

    ysyx_uop_queue #(.UOP_W(UOP_W), .DEPTH(DEPTH), .PASS(1)) u1 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_uop(in_uop),
        .out_valid(out_valid1), .out_ready(out_ready), .out_uop(out_uop1),
        .count(count1)
    );

    // Free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One comparison: counts it, and reports a FAIL line on disagreement.
    task automatic checkOutput(input string name, input logic [UOP_W-1:0] actual,
                               input logic [UOP_W-1:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input logic rst, input logic fl, input logic iv,
                                 input logic [UOP_W-1:0] uop, input logic ordy);
        @(posedge clock);
        #1;
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_uop    = uop;
        out_ready = ordy;
    endtask

    function automatic logic [UOP_W-1:0] randUop();
        logic [UOP_W-1:0] v;
        v = '0;
        for (int i = 0; i < UOP_W / 32; i++) begin
            v = {v[UOP_W-33:0], 32'($urandom)};
        end
        return v;
    endfunction

    // Behavioural model: one plain queue per instance holding live micro-ops.
    logic [UOP_W-1:0] q0[$];
    logic [UOP_W-1:0] q1[$];
    bit known = 0;

    // Every falling edge: compare both DUTs to the model, then advance the
    // model by the transfer the coming rising edge will perform.
    always @(negedge clock) begin
        bit expValid0, expValid1, enq0, deq0, enq1, deq1;
        logic [UOP_W-1:0] expUop1;
        if (known) begin
            expValid0 = (q0.size() > 0) && !flush;
            checkOutput("m0_in_ready", UOP_W'(in_ready0), UOP_W'((q0.size() < DEPTH) && !flush));
            checkOutput("m0_out_valid", UOP_W'(out_valid0), UOP_W'(expValid0));
            checkOutput("m0_count", UOP_W'(count0), UOP_W'(q0.size()));
            if (expValid0) checkOutput("m0_out_uop", out_uop0, q0[0]);

            expValid1 = ((q1.size() > 0) || in_valid) && !flush;
            expUop1   = (q1.size() > 0) ? q1[0] : in_uop;
            checkOutput("m1_in_ready", UOP_W'(in_ready1), UOP_W'((q1.size() < DEPTH) && !flush));
            checkOutput("m1_out_valid", UOP_W'(out_valid1), UOP_W'(expValid1));
            checkOutput("m1_count", UOP_W'(count1), UOP_W'(q1.size()));
            if (expValid1) checkOutput("m1_out_uop", out_uop1, expUop1);
        end
        if (reset) begin
            q0.delete();
            q1.delete();
            known = 1;
        end else if (known) begin
            if (flush) begin
                q0.delete();
                q1.delete();
            end else begin
                deq0 = (q0.size() > 0) && out_ready;
                enq0 = in_valid && (q0.size() < DEPTH);
                if (deq0) void'(q0.pop_front());
                if (enq0) q0.push_back(in_uop);
                if (!(q1.size() == 0 && in_valid && out_ready)) begin
                    deq1 = (q1.size() > 0) && out_ready;
                    enq1 = in_valid && (q1.size() < DEPTH);
                    if (deq1) void'(q1.pop_front());
                    if (enq1) q1.push_back(in_uop);
                end
            end
        end
    end

    // Directed scenarios with hand-computed expectations, then random traffic.
    initial begin
        logic [UOP_W-1:0] vals [10];
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_uop = '0; out_ready = 1'b0;

        applyStimulus(1, 0, 0, '0, 0);
        applyStimulus(1, 0, 0, '0, 0);
        applyStimulus(0, 0, 0, '0, 0);
        @(negedge clock);
        checkOutput("reset_count", UOP_W'(count0), UOP_W'(0));
        checkOutput("reset_in_ready", UOP_W'(in_ready0), UOP_W'(1));
        checkOutput("reset_out_valid", UOP_W'(out_valid0), UOP_W'(0));

        // Fill A,B,C,D with no consumer, then drain in order.
        for (int i = 0; i < 4; i++) vals[i] = UOP_W'(32'hA0 + i);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, vals[i], 0);
        applyStimulus(0, 0, 0, '0, 0);
        @(negedge clock);
        checkOutput("fill_count", UOP_W'(count0), UOP_W'(4));
        checkOutput("fill_in_ready", UOP_W'(in_ready0), UOP_W'(0));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, '0, 1);
            @(negedge clock);
            checkOutput("drain_uop", out_uop0, vals[i]);
        end
        applyStimulus(0, 0, 0, '0, 0);
        @(negedge clock);
        checkOutput("drain_count", UOP_W'(count0), UOP_W'(0));
        checkOutput("drain_out_valid", UOP_W'(out_valid0), UOP_W'(0));

        // Ten back-to-back transfers wrap the pointers twice.
        for (int i = 0; i < 10; i++) vals[i] = randUop();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 1, vals[i], 1);
            @(negedge clock);
            if (i > 0) begin
                checkOutput("wrap_uop", out_uop0, vals[i-1]);
                checkOutput("wrap_count", UOP_W'(count0), UOP_W'(1));
            end
            checkOutput("wrap_bypass_count", UOP_W'(count1), UOP_W'(0));
        end
        applyStimulus(0, 0, 0, '0, 1);
        @(negedge clock);
        checkOutput("wrap_last_uop", out_uop0, vals[9]);

        // Full queue with a simultaneous dequeue rejects the new micro-op.
        for (int i = 0; i < 4; i++) vals[i] = UOP_W'(32'hC0 + i);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, vals[i], 0);
        applyStimulus(0, 0, 1, UOP_W'(32'hEE), 1);
        @(negedge clock);
        checkOutput("full_in_ready", UOP_W'(in_ready0), UOP_W'(0));
        checkOutput("full_head_uop", out_uop0, vals[0]);
        applyStimulus(0, 0, 0, '0, 0);
        @(negedge clock);
        checkOutput("full_count", UOP_W'(count0), UOP_W'(3));

        // Flush wins over a simultaneous enqueue and dequeue.
        applyStimulus(0, 1, 1, UOP_W'(32'hFF), 1);
        @(negedge clock);
        checkOutput("flush_in_ready", UOP_W'(in_ready0), UOP_W'(0));
        checkOutput("flush_out_valid", UOP_W'(out_valid0), UOP_W'(0));
        applyStimulus(0, 0, 0, '0, 0);
        @(negedge clock);
        checkOutput("flush_count", UOP_W'(count0), UOP_W'(0));

        // Same-cycle bypass on the PASS=1 instance, then a stored micro-op.
        applyStimulus(0, 0, 1, UOP_W'(32'h5A), 1);
        @(negedge clock);
        checkOutput("bypass_out_valid", UOP_W'(out_valid1), UOP_W'(1));
        checkOutput("bypass_out_uop", out_uop1, UOP_W'(32'h5A));
        checkOutput("bypass_count", UOP_W'(count1), UOP_W'(0));
        applyStimulus(0, 0, 1, UOP_W'(32'h5A), 0);
        applyStimulus(0, 0, 0, '0, 0);
        @(negedge clock);
        checkOutput("bypass_stored_count", UOP_W'(count1), UOP_W'(1));
        checkOutput("midreset_pre_count", UOP_W'(count0), UOP_W'(2));

        // Reset mid-stream beats a concurrent enqueue.
        applyStimulus(1, 0, 1, UOP_W'(32'h77), 0);
        applyStimulus(0, 0, 0, '0, 0);
        @(negedge clock);
        checkOutput("midreset_count", UOP_W'(count0), UOP_W'(0));
        checkOutput("midreset_in_ready", UOP_W'(in_ready0), UOP_W'(1));
        checkOutput("midreset_out_valid", UOP_W'(out_valid0), UOP_W'(0));

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(99) == 0), ($urandom_range(19) == 0),
                          ($urandom_range(9) < 7), randUop(), ($urandom_range(9) < 6));
        end
        applyStimulus(0, 0, 0, '0, 0);
        @(negedge clock);
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
